// File: rtl/calc_bcd_seq.sv
`default_nettype none
// ============================================================================
// calc_bcd_seq : calculator sequencer, digit-serial BCD add/sub on cbuf.
// Revision: 1.0
// ============================================================================
module calc_bcd_seq #(
    parameter int DIGITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] ibuf,
    input  logic                clear,
    input  logic                plus,
    input  logic                minus,
    input  logic                equal,
    output logic [4*DIGITS-1:0] cbuf,
    output logic                busy,
    output logic                done,
    output logic                ovf,
    output logic                ibuf_clr
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  cbuf_q, cbuf_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          op_q, op_d;      // 1 = subtract
    logic          carry_q, carry_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          ibuf_clr_q, ibuf_clr_d;
    logic          cmd_acc;

    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++)
            r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd9 : v[4*k +: 4];
        return r;
    endfunction

    logic [3:0] a_dig, b_dig, y_dig, r_dig;
    logic [4:0] sum, sum_adj;
    logic       carry_out;

    always_comb begin
        a_dig     = a_q[{idx_q, 2'b00} +: 4];
        b_dig     = b_q[{idx_q, 2'b00} +: 4];
        y_dig     = op_q ? (4'd9 - b_dig) : b_dig;
        sum       = {1'b0, a_dig} + {1'b0, y_dig} + {4'b0000, carry_q};
        sum_adj   = sum - 5'd10;
        carry_out = (sum > 5'd9);
        r_dig     = carry_out ? sum_adj[3:0] : sum[3:0];
    end

    always_comb begin
        state_d = state_q;
        cbuf_d  = cbuf_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        op_d    = op_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        cmd_acc = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE)
                    state_d = IDLE;
                if (clear) begin
                    cbuf_d  = '0;
                    ovf_d   = 1'b0;
                    op_d    = 1'b0;
                    cmd_acc = 1'b1;
                end else if (state_q == IDLE) begin
                    if (plus || minus) begin
                        cbuf_d  = clamp_bcd(ibuf);
                        op_d    = ~plus;
                        ovf_d   = 1'b0;
                        cmd_acc = 1'b1;
                    end else if (equal) begin
                        a_d     = cbuf_q;
                        b_d     = clamp_bcd(ibuf);
                        sh_d    = '0;
                        idx_d   = '0;
                        carry_d = op_q;  // ten's complement: 9-B plus 1
                        state_d = RUN;
                        cmd_acc = 1'b1;
                    end
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = IDLE;
                    cbuf_d  = '0;
                    ovf_d   = 1'b0;
                    op_d    = 1'b0;
                    cmd_acc = 1'b1;
                end else begin
                    sh_d[{idx_q, 2'b00} +: 4] = r_dig;
                    carry_d = carry_out;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cbuf_d  = sh_d;
                        ovf_d   = op_q ? ~carry_out : carry_out;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Back-to-back commands must not stretch the clear request.
        ibuf_clr_d = cmd_acc & ~ibuf_clr_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cbuf_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sh_q       <= '0;
            idx_q      <= '0;
            op_q       <= 1'b0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            ibuf_clr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cbuf_q     <= cbuf_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            ibuf_clr_q <= ibuf_clr_d;
        end
    end

    assign cbuf     = cbuf_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign ibuf_clr = ibuf_clr_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_bcd_seq.sv
`default_nettype none
// ============================================================================
// tb_calc_bcd_seq : randomized bench with a decimal-arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_calc_bcd_seq;
    localparam int     DIGITS = 8;
    localparam int     W      = 4 * DIGITS;
    localparam longint MODV   = 64'd100000000;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] ibuf  = '0;
    logic         clear = 1'b0, plus = 1'b0, minus = 1'b0, equal = 1'b0;
    logic [W-1:0] cbuf;
    logic         busy, done, ovf, ibuf_clr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: accumulator as an integer, pending op, last overflow.
    longint m_acc = 0;
    bit     m_sub = 1'b0;
    bit     m_ovf = 1'b0;

    calc_bcd_seq #(.DIGITS(DIGITS)) dut (
        .clock(clock), .reset(reset), .ibuf(ibuf),
        .clear(clear), .plus(plus), .minus(minus), .equal(equal),
        .cbuf(cbuf), .busy(busy), .done(done), .ovf(ovf), .ibuf_clr(ibuf_clr)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint to_int(input logic [W-1:0] v);
        longint r = 0;
        int     d;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            d = int'(v[4*k +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint n);
        logic [W-1:0] r = '0;
        longint       t = n;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int k = 0; k < DIGITS; k++)
            v[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
        return v;
    endfunction

    // kind: 0 clear, 1 plus, 2 minus
    task automatic do_cmd(input int kind, input logic [W-1:0] val);
        @(negedge clock);
        ibuf = val; clear = (kind == 0); plus = (kind == 1); minus = (kind == 2);
        @(negedge clock);
        clear = 1'b0; plus = 1'b0; minus = 1'b0;
        if (kind == 0) begin m_acc = 0; m_sub = 1'b0; end
        else begin m_acc = to_int(val); m_sub = (kind == 2); end
        m_ovf = 1'b0;
        check("ld_cbuf", cbuf, to_bcd(m_acc));
        check("ld_ovf", ovf, m_ovf);
        check("ld_busy", busy, 0);
        check("ld_iclr", ibuf_clr, 1);
        @(negedge clock);
        check("ld_iclr_off", ibuf_clr, 0);
        check("ld_done", done, 0);
    endtask

    // Equal, optionally with clear (clr_at) or another equal (eq_at) injected in RUN cycle N.
    task automatic do_equal(input logic [W-1:0] val, input int clr_at, input int eq_at);
        logic [W-1:0] old;
        int busy_n = 0, done_n = 0, done_at = 0, partial = 0;
        longint a, b, r;
        old = cbuf;
        @(negedge clock);
        ibuf = val; equal = 1'b1;
        for (int cyc = 1; cyc <= DIGITS + 4; cyc++) begin
            @(negedge clock);
            equal = 1'b0; clear = 1'b0;
            if (cyc == 1) check("eq_iclr", ibuf_clr, 1);
            if (clr_at > 0 && cyc == clr_at + 1) check("abort_iclr", ibuf_clr, 1);
            busy_n += int'(busy);
            if (done) begin done_n++; done_at = cyc; end
            if (cyc <= DIGITS && cbuf !== old && !(clr_at > 0 && cyc > clr_at)) partial++;
            if (cyc == clr_at) clear = 1'b1;
            if (cyc == eq_at) begin equal = 1'b1; ibuf = rand_bcd(); end
        end
        if (clr_at > 0) begin
            m_acc = 0; m_sub = 1'b0; m_ovf = 1'b0;
            check("abort_busy_n", busy_n, clr_at);
            check("abort_done_n", done_n, 0);
        end else begin
            a = m_acc; b = to_int(val);
            if (!m_sub) begin
                r = a + b; m_ovf = (r >= MODV); r = r % MODV;
            end else if (a >= b) begin
                r = a - b; m_ovf = 1'b0;
            end else begin
                r = MODV - b + a; m_ovf = 1'b1;
            end
            m_acc = r;
            check("eq_busy_n", busy_n, DIGITS);
            check("eq_done_n", done_n, 1);
            check("eq_done_at", done_at, DIGITS + 1);
        end
        check("eq_no_partial", partial, 0);
        check("eq_cbuf", cbuf, to_bcd(m_acc));
        check("eq_ovf", ovf, m_ovf);
    endtask

    initial begin
        int seen;
        logic [W-1:0] v;

        repeat (3) @(negedge clock);
        check("rst_cbuf", cbuf, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_iclr", ibuf_clr, 0);
        reset = 1'b1;

        do_cmd(1, 32'h0000_1234);
        do_equal(32'h0000_0766, 0, 0);           // 2000

        do_cmd(2, 32'h0000_0005);
        do_equal(32'h0000_0007, 0, 0);           // 99999998 ovf
        do_cmd(2, 32'h0000_0010);
        do_equal(32'h0000_0003, 0, 0);           // 7
        do_equal(32'h0000_0000, 0, 0);           // SUB by 0, no borrow

        do_cmd(1, 32'h9999_9999);
        do_equal(32'h0000_0001, 0, 0);           // 0 ovf
        do_equal(32'h0000_0000, 0, 0);           // 0 no ovf

        do_cmd(2, 32'h0000_0042);
        do_equal(32'h0000_0005, 4, 0);           // aborted by clear
        do_equal(32'h0000_0005, 0, 0);           // op is ADD again: 5

        // plus and equal together in IDLE: plus wins
        v = 32'h0000_0321;
        @(negedge clock);
        ibuf = v; plus = 1'b1; equal = 1'b1;
        @(negedge clock);
        plus = 1'b0; equal = 1'b0;
        m_acc = to_int(v); m_sub = 1'b0; m_ovf = 1'b0;
        check("pe_cbuf", cbuf, to_bcd(m_acc));
        seen = 0;
        repeat (DIGITS + 2) begin @(negedge clock); seen += int'(busy); end
        check("pe_no_busy", seen, 0);

        do_equal(32'h0000_0123, 0, 3);           // extra equal during RUN ignored

        // asynchronous reset during RUN
        do_cmd(1, 32'h0000_4321);
        @(negedge clock);
        ibuf = 32'h0000_1111; equal = 1'b1;
        @(negedge clock);
        equal = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_cbuf", cbuf, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ovf", ovf, 0);
        @(negedge clock);
        reset = 1'b1;
        m_acc = 0; m_sub = 1'b0; m_ovf = 1'b0;
        seen = 0;
        repeat (DIGITS + 3) begin @(negedge clock); seen += int'(done); end
        check("arst_no_done", seen, 0);

        do_equal(32'h0000_000F, 0, 0);           // clamp: 0 + 9

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0:       do_cmd(0, rand_bcd());
                1:       do_cmd(1, rand_bcd());
                2:       do_cmd(2, rand_bcd());
                default: do_equal(rand_bcd(), 0, 0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
